mult_reservation_station: RTL and testbench

Reservation station feeding the multiplier issue/execute stage. Accepts dispatched multiply instructions from rename/dispatch, holds up to `RSdepth` entries while source operands wait on ROB tags, and snoops the common data bus (CDB) to capture results. It presents the oldest fully ready entry on the `readyRS`/`stallRS` handshake that the multiplier execute stage consumes.

---
 rtl/mult_reservation_station.sv | 177 +++++++++++++++++
 tb/tb_mult_reservation_station.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_reservation_station.sv
// Multiplier reservation station: a collapsing queue of RSdepth entries with CDB snooping.
// Slot 0 is always the oldest entry and occupied slots are contiguous from slot 0.
// The lowest-index entry with both operands ready is offered on readyRS_o/stallRS_i.
// Optional build macro MULT_RS_FLUSH_EN adds a flush_i port that clears the station.
module mult_reservation_station #(
   parameter int unsigned ROBsize    = 32,
   parameter int unsigned ROBsizeLog = $clog2(ROBsize + 1),
   parameter int unsigned RSdepth    = 4
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
`ifdef MULT_RS_FLUSH_EN
   input  logic                  flush_i,
`endif
   input  logic                  dispatchValid_i,
   input  logic [9:0]            dispatchCommands_i,
   input  logic [ROBsizeLog-1:0] dispatchTag_i,
   input  logic [63:0]           dispatchVal1_i,
   input  logic [63:0]           dispatchVal2_i,
   input  logic                  dispatchVal1Ready_i,
   input  logic                  dispatchVal2Ready_i,
   input  logic [ROBsizeLog-1:0] dispatchVal1Tag_i,
   input  logic [ROBsizeLog-1:0] dispatchVal2Tag_i,
   output logic                  dispatchStall_o,
   input  logic                  cdbValid_i,
   input  logic [ROBsizeLog-1:0] cdbTag_i,
   input  logic [63:0]           cdbVal_i,
   output logic [63:0]           reservationStationVal1_o,
   output logic [63:0]           reservationStationVal2_o,
   output logic [9:0]            reservationStationCommands_o,
   output logic [ROBsizeLog-1:0] reservationStationTag_o,
   output logic                  readyRS_o,
   input  logic                  stallRS_i
);

   localparam int unsigned CntW = $clog2(RSdepth + 1);

   typedef struct packed {
      logic [9:0]            cmd;
      logic [ROBsizeLog-1:0] tag;
      logic [63:0]           val1;
      logic                  rdy1;
      logic [ROBsizeLog-1:0] wtag1;
      logic [63:0]           val2;
      logic                  rdy2;
      logic [ROBsizeLog-1:0] wtag2;
   } entry_t;

   entry_t            ent_q [RSdepth];
   entry_t            ent_d [RSdepth];
   // Snooped view of the current slots; the extra zero slot feeds the top slot on a shift.
   entry_t            snp   [RSdepth+1];
   entry_t            new_ent;
   entry_t            iss_ent;
   logic [CntW-1:0]   count_q;
   logic [CntW-1:0]   count_d;
   logic [CntW-1:0]   tail;
   logic [RSdepth-1:0] sel_oh;
   logic              sel_found;
   logic              full;
   logic              do_issue;
   logic              do_disp;
   logic              shift_run;

   assign full      = (count_q == CntW'(RSdepth));
   assign do_issue  = sel_found & ~stallRS_i;
   assign do_disp   = dispatchValid_i & ~full;
   // Slot receiving a dispatch, after any compaction from this cycle's issue.
   assign tail      = count_q - CntW'(do_issue);

   assign dispatchStall_o = full;

   // Apply this cycle's CDB broadcast to every occupied, still-waiting operand.
   always_comb begin
      for (int i = 0; i < int'(RSdepth); i++) begin
         snp[i] = ent_q[i];
         if (cdbValid_i && (i < int'(count_q))) begin
            if (!ent_q[i].rdy1 && (ent_q[i].wtag1 == cdbTag_i)) begin
               snp[i].val1 = cdbVal_i;
               snp[i].rdy1 = 1'b1;
            end
            if (!ent_q[i].rdy2 && (ent_q[i].wtag2 == cdbTag_i)) begin
               snp[i].val2 = cdbVal_i;
               snp[i].rdy2 = 1'b1;
            end
         end
      end
      snp[RSdepth] = '0;
   end

   // Build the incoming entry, capturing a same-cycle CDB result for a waiting operand.
   always_comb begin
      new_ent       = '0;
      new_ent.cmd   = dispatchCommands_i;
      new_ent.tag   = dispatchTag_i;
      new_ent.val1  = dispatchVal1_i;
      new_ent.rdy1  = dispatchVal1Ready_i;
      new_ent.wtag1 = dispatchVal1Tag_i;
      new_ent.val2  = dispatchVal2_i;
      new_ent.rdy2  = dispatchVal2Ready_i;
      new_ent.wtag2 = dispatchVal2Tag_i;
      if (cdbValid_i && !dispatchVal1Ready_i && (dispatchVal1Tag_i == cdbTag_i)) begin
         new_ent.val1 = cdbVal_i;
         new_ent.rdy1 = 1'b1;
      end
      if (cdbValid_i && !dispatchVal2Ready_i && (dispatchVal2Tag_i == cdbTag_i)) begin
         new_ent.val2 = cdbVal_i;
         new_ent.rdy2 = 1'b1;
      end
   end

   // Oldest-first select among registered entries; stallRS_i is deliberately not an input here.
   always_comb begin
      sel_oh    = '0;
      sel_found = 1'b0;
      for (int i = 0; i < int'(RSdepth); i++) begin
         if (!sel_found && (i < int'(count_q)) && ent_q[i].rdy1 && ent_q[i].rdy2) begin
            sel_oh[i] = 1'b1;
            sel_found = 1'b1;
         end
      end
   end

   // Issue mux; all-zero when nothing is selected.
   always_comb begin
      iss_ent = '0;
      for (int i = 0; i < int'(RSdepth); i++) begin
         if (sel_oh[i]) begin
            iss_ent = ent_q[i];
         end
      end
   end

   assign readyRS_o                    = sel_found;
   assign reservationStationVal1_o     = iss_ent.val1;
   assign reservationStationVal2_o     = iss_ent.val2;
   assign reservationStationCommands_o = iss_ent.cmd;
   assign reservationStationTag_o      = iss_ent.tag;

   // Next state: collapse over the issued slot, then place any dispatch at the tail.
   always_comb begin
      shift_run = 1'b0;
      for (int i = 0; i < int'(RSdepth); i++) begin
         shift_run = shift_run | (do_issue & sel_oh[i]);
         ent_d[i]  = shift_run ? snp[i+1] : snp[i];
         if (do_disp && (int'(tail) == i)) begin
            ent_d[i] = new_ent;
         end
      end
      count_d = count_q + CntW'(do_disp) - CntW'(do_issue);
`ifdef MULT_RS_FLUSH_EN
      // Flush wins over any dispatch or issue in the same cycle.
      if (flush_i) begin
         count_d = '0;
         for (int i = 0; i < int'(RSdepth); i++) begin
            ent_d[i] = '0;
         end
      end
`endif
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         count_q <= '0;
         for (int i = 0; i < int'(RSdepth); i++) begin
            ent_q[i] <= '0;
         end
      end else begin
         count_q <= count_d;
         for (int i = 0; i < int'(RSdepth); i++) begin
            ent_q[i] <= ent_d[i];
         end
      end
   end

endmodule

// File: tb/tb_mult_reservation_station.sv
// Self-checking bench for mult_reservation_station: queue-based reference model plus
// an issue scoreboard popped by an independent monitor.
module tb_mult_reservation_station;

   localparam int unsigned ROBsize = 32;
   localparam int unsigned TW      = $clog2(ROBsize + 1);
   localparam int unsigned DEPTH   = 4;

   typedef struct packed {
      logic          dv;
      logic [9:0]    cmd;
      logic [TW-1:0] tag;
      logic [63:0]   v1;
      logic          r1;
      logic [TW-1:0] t1;
      logic [63:0]   v2;
      logic          r2;
      logic [TW-1:0] t2;
      logic          cv;
      logic [TW-1:0] ct;
      logic [63:0]   cval;
      logic          st;
      logic          fl;
   } stim_t;

   typedef struct packed {
      logic [9:0]    cmd;
      logic [TW-1:0] tag;
      logic [63:0]   v1;
      logic          r1;
      logic [TW-1:0] t1;
      logic [63:0]   v2;
      logic          r2;
      logic [TW-1:0] t2;
   } ent_t;

   typedef struct packed {
      logic [9:0]    cmd;
      logic [TW-1:0] tag;
      logic [63:0]   v1;
      logic [63:0]   v2;
   } iss_t;

   logic          clk_i = 1'b0;
   logic          reset_i;
`ifdef MULT_RS_FLUSH_EN
   logic          flush_i;
`endif
   logic          dispatchValid_i;
   logic [9:0]    dispatchCommands_i;
   logic [TW-1:0] dispatchTag_i;
   logic [63:0]   dispatchVal1_i;
   logic [63:0]   dispatchVal2_i;
   logic          dispatchVal1Ready_i;
   logic          dispatchVal2Ready_i;
   logic [TW-1:0] dispatchVal1Tag_i;
   logic [TW-1:0] dispatchVal2Tag_i;
   logic          dispatchStall_o;
   logic          cdbValid_i;
   logic [TW-1:0] cdbTag_i;
   logic [63:0]   cdbVal_i;
   logic [63:0]   rs_val1;
   logic [63:0]   rs_val2;
   logic [9:0]    rs_cmd;
   logic [TW-1:0] rs_tag;
   logic          readyRS_o;
   logic          stallRS_i;

   ent_t mq[$];
   iss_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk_i = ~clk_i;

   mult_reservation_station #(
      .ROBsize (ROBsize),
      .RSdepth (DEPTH)
   ) dut (
      .clk_i                        (clk_i),
      .reset_i                      (reset_i),
`ifdef MULT_RS_FLUSH_EN
      .flush_i                      (flush_i),
`endif
      .dispatchValid_i              (dispatchValid_i),
      .dispatchCommands_i           (dispatchCommands_i),
      .dispatchTag_i                (dispatchTag_i),
      .dispatchVal1_i               (dispatchVal1_i),
      .dispatchVal2_i               (dispatchVal2_i),
      .dispatchVal1Ready_i          (dispatchVal1Ready_i),
      .dispatchVal2Ready_i          (dispatchVal2Ready_i),
      .dispatchVal1Tag_i            (dispatchVal1Tag_i),
      .dispatchVal2Tag_i            (dispatchVal2Tag_i),
      .dispatchStall_o              (dispatchStall_o),
      .cdbValid_i                   (cdbValid_i),
      .cdbTag_i                     (cdbTag_i),
      .cdbVal_i                     (cdbVal_i),
      .reservationStationVal1_o     (rs_val1),
      .reservationStationVal2_o     (rs_val2),
      .reservationStationCommands_o (rs_cmd),
      .reservationStationTag_o      (rs_tag),
      .readyRS_o                    (readyRS_o),
      .stallRS_i                    (stallRS_i)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input stim_t s);
      dispatchValid_i     = s.dv;
      dispatchCommands_i  = s.cmd;
      dispatchTag_i       = s.tag;
      dispatchVal1_i      = s.v1;
      dispatchVal1Ready_i = s.r1;
      dispatchVal1Tag_i   = s.t1;
      dispatchVal2_i      = s.v2;
      dispatchVal2Ready_i = s.r2;
      dispatchVal2Tag_i   = s.t2;
      cdbValid_i          = s.cv;
      cdbTag_i            = s.ct;
      cdbVal_i            = s.cval;
      stallRS_i           = s.st;
`ifdef MULT_RS_FLUSH_EN
      flush_i             = s.fl;
`endif
   endtask

   // One clock of stimulus; called one time unit after a rising edge.
   task automatic cycle(input stim_t s);
      int   k;
      logic full;
      ent_t n;
      iss_t e;
      k = -1;
      foreach (mq[j]) if (k < 0 && mq[j].r1 && mq[j].r2) k = j;
      full = (mq.size() == DEPTH);
      chk("readyRS", readyRS_o, k >= 0);
      chk("dispatchStall", dispatchStall_o, full);
      if (k >= 0) begin
         chk("offer_tag", rs_tag, mq[k].tag);
         chk("offer_val1", rs_val1, mq[k].v1);
         chk("offer_val2", rs_val2, mq[k].v2);
         chk("offer_cmd", rs_cmd, mq[k].cmd);
      end
      drive(s);
      if (s.fl) begin
         mq.delete();
      end else begin
         if (k >= 0 && !s.st) begin
            e.cmd = mq[k].cmd;
            e.tag = mq[k].tag;
            e.v1  = mq[k].v1;
            e.v2  = mq[k].v2;
            exp_q.push_back(e);
         end
         if (s.cv) begin
            foreach (mq[j]) begin
               if (!mq[j].r1 && mq[j].t1 == s.ct) begin mq[j].r1 = 1'b1; mq[j].v1 = s.cval; end
               if (!mq[j].r2 && mq[j].t2 == s.ct) begin mq[j].r2 = 1'b1; mq[j].v2 = s.cval; end
            end
         end
         if (k >= 0 && !s.st) mq.delete(k);
         if (s.dv && !full) begin
            n.cmd = s.cmd; n.tag = s.tag;
            n.v1 = s.v1; n.r1 = s.r1; n.t1 = s.t1;
            n.v2 = s.v2; n.r2 = s.r2; n.t2 = s.t2;
            if (s.cv && !n.r1 && n.t1 == s.ct) begin n.r1 = 1'b1; n.v1 = s.cval; end
            if (s.cv && !n.r2 && n.t2 == s.ct) begin n.r2 = 1'b1; n.v2 = s.cval; end
            mq.push_back(n);
         end
      end
      @(posedge clk_i);
      #1;
   endtask

   function automatic stim_t disp(input logic [TW-1:0] tag, input logic [63:0] v1,
                                  input logic r1, input logic [TW-1:0] t1,
                                  input logic [63:0] v2, input logic r2,
                                  input logic [TW-1:0] t2, input logic st);
      stim_t s;
      s     = '0;
      s.dv  = 1'b1;
      s.cmd = 10'h100 | 10'(tag);
      s.tag = tag;
      s.v1  = v1; s.r1 = r1; s.t1 = t1;
      s.v2  = v2; s.r2 = r2; s.t2 = t2;
      s.st  = st;
      return s;
   endfunction

   function automatic stim_t cdb(input logic [TW-1:0] ct, input logic [63:0] cval,
                                 input logic st);
      stim_t s;
      s      = '0;
      s.cv   = 1'b1;
      s.ct   = ct;
      s.cval = cval;
      s.st   = st;
      return s;
   endfunction

   function automatic stim_t idle(input logic st);
      stim_t s;
      s    = '0;
      s.st = st;
      return s;
   endfunction

   // Monitor: every accepted issue must match the oldest scoreboard entry.
   always @(negedge clk_i) begin
      iss_t e;
      if (reset_i) begin
         if (readyRS_o && !stallRS_i) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_issue actual_tag=%0h required=none at %0t", rs_tag, $time);
            end else begin
               e = exp_q.pop_front();
               chk("issue_tag", rs_tag, e.tag);
               chk("issue_val1", rs_val1, e.v1);
               chk("issue_val2", rs_val2, e.v2);
               chk("issue_cmd", rs_cmd, e.cmd);
            end
         end else if (!readyRS_o) begin
            chk("idle_val1_zero", rs_val1, 64'd0);
            chk("idle_val2_zero", rs_val2, 64'd0);
            chk("idle_tag_zero", rs_tag, 64'd0);
            chk("idle_cmd_zero", rs_cmd, 64'd0);
         end
      end
   end

   initial begin
      stim_t s;
      reset_i = 1'b0;
      drive(idle(1'b0));
      #12;
      chk("reset_readyRS", readyRS_o, 1'b0);
      chk("reset_stall", dispatchStall_o, 1'b0);
      chk("reset_val1", rs_val1, 64'd0);
      chk("reset_tag", rs_tag, 64'd0);
      #1 reset_i = 1'b1;
      @(posedge clk_i);
      #1;

      // Ready dispatch.
      cycle(disp(5, 3, 1, 0, 7, 1, 0, 1'b0));
      chk("t1_ready", readyRS_o, 1'b1);
      chk("t1_val1", rs_val1, 64'd3);
      chk("t1_val2", rs_val2, 64'd7);
      chk("t1_tag", rs_tag, 64'd5);
      cycle(idle(1'b0));
      chk("t1_gone", readyRS_o, 1'b0);

      // CDB wakeup.
      cycle(disp(6, 1, 1, 0, 0, 0, 9, 1'b0));
      cycle(idle(1'b0));
      chk("t2_waiting", readyRS_o, 1'b0);
      cycle(cdb(9, 64'h10, 1'b0));
      chk("t2_woken", readyRS_o, 1'b1);
      chk("t2_val2", rs_val2, 64'h10);
      cycle(idle(1'b0));

      // Dispatch-cycle bypass.
      s = disp(7, 0, 0, 4, 2, 1, 0, 1'b0);
      s.cv = 1'b1; s.ct = 4; s.cval = 64'h22;
      cycle(s);
      chk("t3_ready", readyRS_o, 1'b1);
      chk("t3_val1", rs_val1, 64'h22);
      cycle(idle(1'b0));

      // Full and stall: fifth dispatch dropped, then drain in order.
      for (int i = 0; i < 5; i++) begin
         cycle(disp(TW'(10 + i), 64'(i), 1, 0, 64'(i + 100), 1, 0, 1'b1));
         if (i == 3) chk("t4_full", dispatchStall_o, 1'b1);
      end
      for (int i = 0; i < 4; i++) cycle(idle(1'b0));
      chk("t4_drained", readyRS_o, 1'b0);

      // Age order, then simultaneous dispatch and issue.
      cycle(disp(20, 0, 0, 11, 5, 1, 0, 1'b1));
      cycle(disp(21, 8, 1, 0, 9, 1, 0, 1'b1));
      chk("t5_b_first", rs_tag, 64'd21);
      cycle(idle(1'b0));
      cycle(cdb(11, 64'h33, 1'b1));
      chk("t5_a_tag", rs_tag, 64'd20);
      cycle(disp(22, 1, 1, 0, 2, 1, 0, 1'b0));
      chk("t5_c_tag", rs_tag, 64'd22);
      chk("t5_not_full", dispatchStall_o, 1'b0);
      cycle(idle(1'b0));

`ifdef MULT_RS_FLUSH_EN
      for (int i = 0; i < 3; i++) cycle(disp(TW'(24 + i), 1, 1, 0, 1, 1, 0, 1'b1));
      s = idle(1'b1);
      s.fl = 1'b1;
      cycle(s);
      chk("flush_ready", readyRS_o, 1'b0);
      chk("flush_stall", dispatchStall_o, 1'b0);
      s.fl = 1'b0;
`endif

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         s      = '0;
         s.dv   = ($urandom_range(0, 9) < 6);
         s.cmd  = 10'($urandom);
         s.tag  = TW'($urandom_range(0, 31));
         s.v1   = {$urandom, $urandom};
         s.r1   = ($urandom_range(0, 2) != 0);
         s.t1   = TW'($urandom_range(0, 7));
         s.v2   = {$urandom, $urandom};
         s.r2   = ($urandom_range(0, 2) != 0);
         s.t2   = TW'($urandom_range(0, 7));
         s.cv   = ($urandom_range(0, 1) == 1);
         s.ct   = TW'($urandom_range(0, 7));
         s.cval = {$urandom, $urandom};
         s.st   = ($urandom_range(0, 9) < 3);
         cycle(s);
      end

      // Asynchronous reset mid-stream.
      for (int i = 0; i < 3; i++) cycle(disp(TW'(28 + i), 4, 1, 0, 4, 1, 0, 1'b1));
      drive(idle(1'b1));
      #1 reset_i = 1'b0;
      #1;
      chk("rst_mid_ready", readyRS_o, 1'b0);
      chk("rst_mid_stall", dispatchStall_o, 1'b0);
      chk("rst_mid_tag", rs_tag, 64'd0);
      chk("rst_mid_val1", rs_val1, 64'd0);
      mq.delete();
      exp_q.delete();
      @(negedge clk_i);
      #1 reset_i = 1'b1;
      @(posedge clk_i);
      #1;
      cycle(idle(1'b0));
      chk("rst_after_ready", readyRS_o, 1'b0);

      chk("scoreboard_empty", exp_q.size(), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
